serial_subtractor: RTL and testbench

//  Multi-cycle digit-serial subtractor: o_diff = A - B - i_borrow, one DIGIT-bit slice per clock, LSB first.

---
 rtl/serial_subtractor_if.sv | 42 ++++
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// SERIAL_SUB_COMPARE_EN adds the o_lt/o_ltu/o_eq compare outputs.
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             i_start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             i_borrow;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
    logic             o_zero;
    logic             o_neg;
    logic             o_ovf;
`ifdef SERIAL_SUB_COMPARE_EN
    logic             o_lt;
    logic             o_ltu;
    logic             o_eq;

    modport master (
        output i_start, A, B, i_borrow,
        input  o_busy, o_done, o_diff, o_borrow, o_zero, o_neg, o_ovf,
        input  o_lt, o_ltu, o_eq
    );
    modport slave (
        input  i_start, A, B, i_borrow,
        output o_busy, o_done, o_diff, o_borrow, o_zero, o_neg, o_ovf,
        output o_lt, o_ltu, o_eq
    );
`else
    modport master (
        output i_start, A, B, i_borrow,
        input  o_busy, o_done, o_diff, o_borrow, o_zero, o_neg, o_ovf
    );
    modport slave (
        input  i_start, A, B, i_borrow,
        output o_busy, o_done, o_diff, o_borrow, o_zero, o_neg, o_ovf
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = A - B - borrow_in, DIGIT bits per clock, LSB first.
// SERIAL_SUB_COMPARE_EN builds the signed/unsigned/equal compare outputs.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic              i_clk,
    input logic              i_rst_n,
    serial_subtractor_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if ((WIDTH % DIGIT) != 0) begin : g_width_check
        $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
    end

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;

    logic [DIGIT:0]   w_slice;
    logic [WIDTH-1:0] w_dig_ext;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;
    logic             w_ovf_next;

    // A - B as A + ~B + carry, with carry seeded to ~borrow_in
    assign w_slice    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, ~r_b[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, r_carry};
    assign w_dig_ext  = WIDTH'(w_slice[DIGIT-1:0]);
    assign w_res_next = (r_res >> DIGIT) | (w_dig_ext << (WIDTH - DIGIT));
    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_ovf_next = (r_a_msb != r_b_msb) & (w_res_next[WIDTH-1] != r_a_msb);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.i_start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_a_msb <= bus.A[WIDTH-1];
                        r_b_msb <= bus.B[WIDTH-1];
                        r_carry <= ~bus.i_borrow;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_slice[DIGIT];
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff   <= w_res_next;
                        r_borrow <= ~w_slice[DIGIT];
                        r_zero   <= ~|w_res_next;
                        r_neg    <= w_res_next[WIDTH-1];
                        r_ovf    <= w_ovf_next;
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy   = (r_state == S_RUN);
    assign bus.o_done   = (r_state == S_DONE);
    assign bus.o_diff   = r_diff;
    assign bus.o_borrow = r_borrow;
    assign bus.o_zero   = r_zero;
    assign bus.o_neg    = r_neg;
    assign bus.o_ovf    = r_ovf;

`ifdef SERIAL_SUB_COMPARE_EN
    assign bus.o_lt  = r_neg ^ r_ovf;
    assign bus.o_ltu = r_borrow;
    assign bus.o_eq  = r_zero;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=16, DIGIT=4).
module tb_serial_subtractor;
    localparam int W = 16;
    localparam int N = 4;

    logic i_clk;
    logic i_rst_n;
    int   total;
    int   bad;
    int   cyc;
    int   dones;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands and pulse start across one rising edge; returns #1 after that edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        bus.A        = a;
        bus.B        = b;
        bus.i_borrow = bin;
        bus.i_start  = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_start  = 1'b0;
    endtask

    // Counts edges after the accepting edge until o_done, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.o_done && n < 20) begin
            @(posedge i_clk);
            #1;
            n++;
        end
    endtask

    task automatic check_flags(input string tag, input logic [W-1:0] d, input logic bo,
                               input logic z, input logic ng, input logic ov);
        chk({tag, "_diff"},   32'(bus.o_diff),   32'(d));
        chk({tag, "_borrow"}, 32'(bus.o_borrow), 32'(bo));
        chk({tag, "_zero"},   32'(bus.o_zero),   32'(z));
        chk({tag, "_neg"},    32'(bus.o_neg),    32'(ng));
        chk({tag, "_ovf"},    32'(bus.o_ovf),    32'(ov));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] d, input logic bo,
                          input logic z, input logic ng, input logic ov);
        int n;
        launch(a, b, bin);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
        wait_done(n);
        chk({tag, "_lat"}, 32'(n), 32'(N));
        chk({tag, "_busy_at_done"}, 32'(bus.o_busy), 32'd0);
        check_flags(tag, d, bo, z, ng, ov);
        @(posedge i_clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(bus.o_done), 32'd0);
        chk({tag, "_hold"}, 32'(bus.o_diff), 32'(d));
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        bus.i_start  = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.i_borrow = 1'b0;
        i_rst_n      = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_flags("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        run_op("t1",   16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("t2",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("t3a",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("t3b",  16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("wrap", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("povf", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);

        // Starts during RUN are ignored; result must come from the first operands.
        launch(16'h0010, 16'h0001, 1'b0);
        chk("ign_hold_prev", 32'(bus.o_diff), 32'h8000);
        bus.A = 16'hFFFF; bus.B = 16'h0000; bus.i_start = 1'b1;
        @(posedge i_clk); #1;
        bus.A = 16'h1111; bus.B = 16'h2222;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        chk("ign_busy", 32'(bus.o_busy), 32'd1);
        wait_done(cyc);
        chk("ign_lat", 32'(cyc), 32'd2);
        chk("ign_diff", 32'(bus.o_diff), 32'h000F);

        // Back-to-back: start sampled in the DONE cycle.
        launch(16'h0100, 16'h0001, 1'b0);
        chk("b2b_busy", 32'(bus.o_busy), 32'd1);
        chk("b2b_hold", 32'(bus.o_diff), 32'h000F);
        dones = 0;
        wait_done(cyc);
        chk("b2b_lat", 32'(cyc), 32'(N));
        check_flags("b2b", 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) begin
            @(posedge i_clk); #1;
            if (bus.o_done) dones++;
        end
        chk("b2b_single_done", 32'(dones), 32'd0);

        // Reset in RUN cycle 2 aborts the op.
        launch(16'h0007, 16'h0002, 1'b0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        check_flags("arst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("arst_busy", 32'(bus.o_busy), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(posedge i_clk); #1;
            if (bus.o_done) dones++;
        end
        chk("arst_no_done", 32'(dones), 32'd0);
        run_op("post", 16'h0007, 16'h0002, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_SUB_COMPARE_EN
        run_op("c1", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("c1_lt",  32'(bus.o_lt),  32'd1);
        chk("c1_ltu", 32'(bus.o_ltu), 32'd0);
        chk("c1_eq",  32'(bus.o_eq),  32'd0);
        run_op("c2", 16'h00AA, 16'h00AA, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("c2_lt",  32'(bus.o_lt),  32'd0);
        chk("c2_ltu", 32'(bus.o_ltu), 32'd0);
        chk("c2_eq",  32'(bus.o_eq),  32'd1);
        run_op("c3", 16'h0001, 16'h8000, 1'b0, 16'h8001, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("c3_lt",  32'(bus.o_lt),  32'd0);
        chk("c3_ltu", 32'(bus.o_ltu), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
